div32_seq: RTL and testbench

//   Multi-cycle unsigned 32-bit divider sequencer (restoring algorithm).

---
 rtl/div32_seq.sv | 96 +++++++++
 tb/tb_div32_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle unsigned restoring divider that drives an external shared add/sub unit.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic [WIDTH-1:0] add_a_o,
    output logic [WIDTH-1:0] add_b_o,
    output logic             add_sub_o,
    input  logic [WIDTH-1:0] add_s_i,
    input  logic             add_co_i
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d, q_q, q_d, r_q, r_d, quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] rs;
    logic             qbit;
    // Shifted partial remainder; the bit shifted out of R is the 33rd bit of the trial value.
    assign rs        = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign qbit      = r_q[WIDTH-1] | add_co_i;
    assign busy_o    = state_q == CALC;
    assign done_o    = state_q == DONE;
    assign add_a_o   = busy_o ? rs : '0;
    assign add_b_o   = busy_o ? d_q : '0;
    assign add_sub_o = busy_o;
    assign div_by_zero_o = dbz_q;
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (start_i) begin
                d_d   = divisor_i;
                q_d   = dividend_i;
                r_d   = '0;
                cnt_d = CW'(WIDTH - 1);
                dbz_d = divisor_i == '0;
                state_d = dbz_d ? DONE : CALC;
                if (dbz_d) begin
                    quo_d = '1;
                    rem_d = dividend_i;
                end
            end
            CALC: begin
                r_d   = qbit ? add_s_i : rs;
                q_d   = {q_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    rem_d   = r_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: randomized scoreboard bench for div32_seq against plain / and % arithmetic.
module tb_div32_seq;
    logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0;
    logic [31:0] dividend_i = '0, divisor_i = '0;
    logic        busy_o, done_o, div_by_zero_o, add_sub_o, add_co_i;
    logic [31:0] quotient_o, remainder_o, add_a_o, add_b_o, add_s_i;

    div32_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
        .busy_o(busy_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o),
        .quotient_o(quotient_o), .remainder_o(remainder_o),
        .add_a_o(add_a_o), .add_b_o(add_b_o), .add_sub_o(add_sub_o),
        .add_s_i(add_s_i), .add_co_i(add_co_i)
    );

    // The shared add/sub unit the divider borrows.
    assign {add_co_i, add_s_i} = {1'b0, add_a_o} + {1'b0, add_b_o ^ {32{add_sub_o}}} + 33'(add_sub_o);

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          c;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int cyc = 0, checks = 0, failures = 0, dones = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) if (!rst) begin
        chk("busy_done_excl", 32'(busy_o & done_o), 32'd0);
        if (!busy_o) begin
            chk("add_a_idle", add_a_o, 32'd0);
            chk("add_b_idle", add_b_o, 32'd0);
            chk("add_sub_idle", 32'(add_sub_o), 32'd0);
        end
        if (done_o) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=1 exp=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient_o, e.q);
                chk("remainder", remainder_o, e.r);
                chk("div_by_zero", 32'(div_by_zero_o), 32'(e.z));
                chk("done_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t x;
        @(negedge clk);
        start_i = 1'b1;
        dividend_i = a;
        divisor_i = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        x.q = (b == 0) ? 32'hFFFF_FFFF : a / b;
        x.r = (b == 0) ? a : a % b;
        x.z = (b == 0);
        x.c = cyc + ((b == 0) ? 0 : 32);
        if (push) sb.push_back(x);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o) return;
        end
        checks++;
        failures++;
        $display("FAIL done_timeout got=0 exp=1 (cycle %0d)", cyc);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_dbz", 32'(div_by_zero_o), 0);
        chk("rst_quotient", quotient_o, 0);
        chk("rst_remainder", remainder_o, 0);
        chk("rst_add_a", add_a_o, 0);
        rst = 1'b0;

        issue(100, 7, 1);                  wait_done();
        issue(32'hFFFF_FFFF, 32'h8000_0001, 1); wait_done();
        issue(32'hFFFF_FFFF, 1, 1);        wait_done();
        repeat (3) @(negedge clk);
        chk("held_quotient", quotient_o, 32'hFFFF_FFFF);
        chk("held_remainder", remainder_o, 32'd0);
        issue(5, 0, 1);
        chk("dbz_no_busy", 32'(busy_o), 0);
        wait_done();

        // A start raised mid-calculation must be dropped entirely.
        issue(100, 7, 1);
        repeat (9) @(negedge clk);
        start_i = 1'b1;
        dividend_i = 9;
        divisor_i = 3;
        @(negedge clk);
        start_i = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // Reset in the middle of a calculation aborts it without a done pulse.
        issue(100, 7, 0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_done", 32'(done_o), 0);
        chk("abort_dbz", 32'(div_by_zero_o), 0);
        chk("abort_quotient", quotient_o, 0);
        chk("abort_remainder", remainder_o, 0);
        d0 = dones;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(dones), 32'(d0));
        issue(9, 3, 1);                    wait_done();

        for (int i = 0; i < 1200; i++) begin
            issue(pick(), pick(), 1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
